// File: rtl/delay_sched_pkg.sv
// Shared types and constants for the delay scheduler.
// Holds the FSM state enum and the req_delay slice helper.
package delay_sched_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int CNT_W_DEF   = 8;

   // Upper bounds the slice helper is sized for.
   localparam int MAX_REQ   = 8;
   localparam int MAX_CNT_W = 32;
   localparam int MAX_BUS   = MAX_REQ * MAX_CNT_W;

   typedef enum logic {
      ST_IDLE,
      ST_COUNT
   } state_t;

   // Extract slice idx of width w from a packed delay bus.
   // Bits at or above w are forced to zero.
   function automatic logic [MAX_CNT_W-1:0] delay_at(
      input logic [MAX_BUS-1:0] bus,
      input int                 idx,
      input int                 w
   );
      logic [MAX_CNT_W-1:0] r;
      r = MAX_CNT_W'(bus >> (idx * w));
      for (int b = 0; b < MAX_CNT_W; b++) begin
         if (b >= w) r[b] = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Returns the first set bit of pending after rr_last, wrapping.
module rr_picker
   import delay_sched_pkg::*;
#(
   parameter int N = NUM_REQ_DEF
) (
   input  logic [N-1:0]         pending,
   input  logic [$clog2(N)-1:0] rr_last,
   output logic                 any,
   output logic [$clog2(N)-1:0] grant
);

   localparam int W = $clog2(N);

   // Scan N positions starting one past the last winner.
   always_comb begin
      int idx;
      idx   = 0;
      any   = 1'b0;
      grant = '0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(rr_last) + k) % N;
         if (!any && pending[idx]) begin
            any   = 1'b1;
            grant = idx[W-1:0];
         end
      end
   end

endmodule

// File: rtl/delay_scheduler.sv
// One shared down-counter serving NUM_REQ one-shot delay requests.
// Requests are latched, granted round-robin, and answered with done.
module delay_scheduler
   import delay_sched_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         cancel,
   input  logic [NUM_REQ*CNT_W-1:0]   req_delay,
   output logic [NUM_REQ-1:0]         done,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] active_ch
);

   localparam int IDX_W = $clog2(NUM_REQ);

   state_t             state;
   logic [NUM_REQ-1:0] pending;
   logic [NUM_REQ-1:0] pend_next;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] gmask;
   logic [CNT_W-1:0]   counter;
   logic [CNT_W-1:0]   cnt_load;
   logic [IDX_W-1:0]   rr_last;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic [MAX_BUS-1:0] delay_ext;

   // A channel cancelled on this edge is never granted on it.
   assign elig = pending & ~cancel;

   rr_picker #(
      .N (NUM_REQ)
   ) u_pick (
      .pending (elig),
      .rr_last (rr_last),
      .any     (pick_any),
      .grant   (pick_idx)
   );

   // Widen the delay bus so the shared slice helper can index it.
   always_comb begin
      delay_ext = '0;
      delay_ext[NUM_REQ*CNT_W-1:0] = req_delay;
   end

   assign cnt_load = CNT_W'(delay_at(delay_ext, int'(pick_idx), CNT_W));

   // Next pending: drop the granted bit, add new reqs, cancel wins.
   always_comb begin
      gmask = '0;
      if (state == ST_IDLE && pick_any) gmask[pick_idx] = 1'b1;
      pend_next = ((pending & ~gmask) | req) & ~cancel;
   end

   // Scheduler FSM with counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         pending   <= '0;
         counter   <= '0;
         active_ch <= '0;
         rr_last   <= IDX_W'(NUM_REQ - 1);
         busy      <= 1'b0;
         done      <= '0;
      end else begin
         done    <= '0;
         pending <= pend_next;
         unique case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  counter   <= cnt_load;
                  active_ch <= pick_idx;
                  rr_last   <= pick_idx;
                  busy      <= 1'b1;
                  state     <= ST_COUNT;
               end
            end
            ST_COUNT: begin
               if (cancel[active_ch]) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else if (counter == '0) begin
                  done[active_ch] <= 1'b1;
                  busy            <= 1'b0;
                  state           <= ST_IDLE;
               end else begin
                  counter <= counter - CNT_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_delay_scheduler.sv
// Self-checking bench for delay_scheduler.
// Directed tables, corner sequences and a random run against a job model.
module tb_delay_scheduler;

   localparam int N = 4;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] req;
   logic [N-1:0] cancel;
   logic [N*W-1:0] req_delay;
   logic [N-1:0] done;
   logic         busy;
   logic [1:0]   active_ch;

   delay_scheduler #(.NUM_REQ(N), .CNT_W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .cancel    (cancel),
      .req_delay (req_delay),
      .done      (done),
      .busy      (busy),
      .active_ch (active_ch)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   longint t = 0;

   // Job-level model: one active job with an absolute finish edge.
   logic [N-1:0] m_pend;
   logic [N-1:0] m_done;
   bit           m_act;
   int           m_ch;
   int           m_last;
   longint       m_fin;

   typedef struct {
      logic [N-1:0] rq;
      logic [N-1:0] xdone;
      logic         xbusy;
   } vec_t;

   vec_t vec [10];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)",
                  name, act, exp, t);
      end
   endtask

   function automatic int dly(input int c);
      return int'(req_delay[c*W +: W]);
   endfunction

   task automatic set_dly(input int c, input int d);
      req_delay[c*W +: W] = W'(d);
   endtask

   task automatic model_step(input logic r, input logic [N-1:0] rq,
                             input logic [N-1:0] cn);
      logic [N-1:0] elig;
      logic [N-1:0] gm;
      bit found;
      int c;
      m_done = '0;
      gm = '0;
      found = 0;
      if (r) begin
         m_pend = '0;
         m_act  = 0;
         m_ch   = 0;
         m_last = N - 1;
      end else begin
         if (m_act) begin
            if (cn[m_ch]) m_act = 0;
            else if (t == m_fin) begin
               m_done[m_ch] = 1'b1;
               m_act = 0;
            end
         end else begin
            elig = m_pend & ~cn;
            for (int k = 1; k <= N; k++) begin
               c = (m_last + k) % N;
               if (!found && elig[c]) begin
                  found  = 1;
                  m_ch   = c;
                  m_last = c;
                  m_act  = 1;
                  m_fin  = t + dly(c) + 1;
                  gm[c]  = 1'b1;
               end
            end
         end
         m_pend = ((m_pend & ~gm) | rq) & ~cn;
      end
   endtask

   task automatic cycle(input logic r, input logic [N-1:0] rq,
                        input logic [N-1:0] cn);
      reset  = r;
      req    = rq;
      cancel = cn;
      @(posedge clk);
      t++;
      model_step(r, rq, cn);
      #1;
      reset  = 1'b0;
      req    = '0;
      cancel = '0;
      chk("model done", int'(done), int'(m_done));
      chk("model busy", int'(busy), int'(m_act));
      if (m_act) chk("model active_ch", int'(active_ch), m_ch);
      if ($countones(done) > 1) chk("done onehot", $countones(done), 1);
   endtask

   task automatic wait_done(input int ch, input int maxc, output int n);
      n = 0;
      for (int i = 0; i < maxc; i++) begin
         cycle(1'b0, '0, '0);
         n++;
         if (done[ch]) break;
      end
      if (!done[ch]) chk("wait_done timeout", 0, 1);
   endtask

   initial begin
      int n;
      int cnt;
      int first [N];
      reset = 1'b1;
      req = '0;
      cancel = '0;
      req_delay = '0;
      m_pend = '0;
      m_done = '0;
      m_act = 0;
      m_ch = 0;
      m_last = N - 1;
      m_fin = 0;

      // Reset state
      cycle(1'b1, '0, '0);
      chk("reset done", int'(done), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset active_ch", int'(active_ch), 0);

      // Test 1: single request, table driven, D=5 on ch1
      vec[0] = '{4'b0010, 4'b0000, 1'b0};
      for (int i = 1; i <= 6; i++) vec[i] = '{4'b0000, 4'b0000, 1'b1};
      vec[7] = '{4'b0000, 4'b0010, 1'b0};
      vec[8] = '{4'b0000, 4'b0000, 1'b0};
      vec[9] = '{4'b0000, 4'b0000, 1'b0};
      set_dly(1, 5);
      while (t < 9) cycle(1'b0, '0, '0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, vec[i].rq, '0);
         chk("t1 done", int'(done), int'(vec[i].xdone));
         chk("t1 busy", int'(busy), int'(vec[i].xbusy));
         if (vec[i].xbusy) chk("t1 active_ch", int'(active_ch), 1);
      end

      // Test 2: D=0 and D=255 on channel 0
      set_dly(0, 0);
      cycle(1'b0, 4'b0001, '0);
      wait_done(0, 10, n);
      chk("t2 D=0 latency", n, 2);
      cycle(1'b0, '0, '0);
      set_dly(0, 255);
      cycle(1'b0, 4'b0001, '0);
      wait_done(0, 300, n);
      chk("t2 D=255 latency", n, 257);
      cycle(1'b0, '0, '0);

      // Test 3: all four at once, D=3, from reset arbitration state
      cycle(1'b1, '0, '0);
      for (int c = 0; c < N; c++) set_dly(c, 3);
      for (int c = 0; c < N; c++) first[c] = -1;
      cycle(1'b0, 4'b1111, '0);
      for (int i = 1; i <= 30; i++) begin
         cycle(1'b0, '0, '0);
         for (int c = 0; c < N; c++)
            if (done[c] && first[c] < 0) first[c] = i;
      end
      chk("t3 ch0 done", first[0], 5);
      chk("t3 ch1 done", first[1], 10);
      chk("t3 ch2 done", first[2], 15);
      chk("t3 ch3 done", first[3], 20);
      cycle(1'b0, 4'b1001, '0);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, '0, '0);
         if (done != '0) begin
            chk("t3 rr first", int'(done), 1);
            cnt = 1;
            break;
         end
      end
      chk("t3 rr seen", cnt, 1);
      repeat (10) cycle(1'b0, '0, '0);

      // Test 4: merge while pending, re-request while active
      cycle(1'b1, '0, '0);
      set_dly(0, 10);
      set_dly(2, 2);
      cnt = 0;
      cycle(1'b0, 4'b0001, '0);
      cycle(1'b0, '0, '0);
      cycle(1'b0, 4'b0100, '0);
      cycle(1'b0, '0, '0);
      cycle(1'b0, 4'b0100, '0);
      for (int i = 0; i < 25; i++) begin
         cycle(1'b0, '0, '0);
         if (done[2]) cnt++;
      end
      chk("t4 merged done2", cnt, 1);
      set_dly(2, 4);
      cnt = 0;
      cycle(1'b0, 4'b0100, '0);
      cycle(1'b0, '0, '0);
      cycle(1'b0, 4'b0100, '0);
      for (int i = 0; i < 30; i++) begin
         cycle(1'b0, '0, '0);
         if (done[2]) cnt++;
      end
      chk("t4 requeued done2", cnt, 2);

      // Test 5: cancel active channel, then req+cancel together
      cycle(1'b1, '0, '0);
      set_dly(1, 20);
      set_dly(3, 1);
      cycle(1'b0, 4'b0010, '0);
      cycle(1'b0, '0, '0);
      cycle(1'b0, 4'b1000, '0);
      cycle(1'b0, '0, '0);
      cycle(1'b0, '0, '0);
      cycle(1'b0, '0, 4'b0010);
      chk("t5 busy after cancel", int'(busy), 0);
      chk("t5 no done on cancel", int'(done), 0);
      cycle(1'b0, '0, '0);
      chk("t5 next grant busy", int'(busy), 1);
      chk("t5 next grant ch", int'(active_ch), 3);
      cnt = 0;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         cycle(1'b0, '0, '0);
         if (done[1]) cnt++;
         if (done[3]) n++;
      end
      chk("t5 done1 count", cnt, 0);
      chk("t5 done3 count", n, 1);
      cycle(1'b0, 4'b0100, 4'b0100);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, '0, '0);
         if (busy || done != '0) cnt++;
      end
      chk("t5 req+cancel ignored", cnt, 0);

      // Test 6: reset mid-count with two pending
      set_dly(0, 50);
      cycle(1'b0, 4'b0001, '0);
      cycle(1'b0, '0, '0);
      cycle(1'b0, 4'b0110, '0);
      repeat (10) cycle(1'b0, '0, '0);
      cycle(1'b1, '0, '0);
      chk("t6 done after reset", int'(done), 0);
      chk("t6 busy after reset", int'(busy), 0);
      chk("t6 active_ch after reset", int'(active_ch), 0);
      cnt = 0;
      for (int i = 0; i < 120; i++) begin
         cycle(1'b0, '0, '0);
         if (done != '0 || busy) cnt++;
      end
      chk("t6 silent after reset", cnt, 0);

      // Random run against the model
      for (int i = 0; i < 4000; i++) begin
         logic [N-1:0] rq;
         logic [N-1:0] cn;
         logic r;
         rq = '0;
         cn = '0;
         for (int c = 0; c < N; c++) begin
            if ($urandom_range(0, 5) == 0) rq[c] = 1'b1;
            if ($urandom_range(0, 24) == 0) cn[c] = 1'b1;
            if ($urandom_range(0, 7) == 0)
               set_dly(c, int'($urandom_range(0, 12)));
         end
         r = ($urandom_range(0, 499) == 0);
         cycle(r, rq, cn);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
